alu_rr_arbiter: RTL and testbench

Shares one combinational `ALU_4bit` between two independent requesters. Each requester sends operands and an opcode over a valid/ready handshake. The block arbitrates round-robin, latches the winning operation, drives the shared ALU, and captures `out`/`cout`. It returns them on that requester's response channel, which supports backpressure. It sits between the two issuing engines and the single ALU instance.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 16 +
 rtl/alu_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and arbiter FSM encoding
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b1100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b1101;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1110;
  localparam logic [OP_W-1:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic op_known(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NOT, OP_OR, OP_AND,
      OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_PASS: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick from valids and the last grant
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic winner,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    // On a tie the requester not served last wins; otherwise whoever is valid.
    winner    = (valid0 && valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - shares one external 4-bit ALU between two requesters
module alu_rr_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_out,
  output logic              resp0_cout,
  output logic              resp0_err,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_out,
  output logic              resp1_cout,
  output logic              resp1_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic              busy
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic                winner, any_valid;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic                cin_q, tag_q, cout_q, err_q;
  logic                resp_hs;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Ready is masked during reset so nothing can look accepted while rst is high.
  assign req0_ready = !rst && (state == ST_IDLE) && any_valid && !winner;
  assign req1_ready = !rst && (state == ST_IDLE) && any_valid &&  winner;
  assign resp_hs    = (state == ST_RESP) && (tag_q ? resp1_ready : resp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (resp_hs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      tag_q      <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            tag_q <= winner;
            op_q  <= winner ? req1_opcode : req0_opcode;
            a_q   <= winner ? req1_a      : req0_a;
            b_q   <= winner ? req1_b      : req0_b;
            cin_q <= winner ? req1_cin    : req0_cin;
          end
        end
        ST_ISSUE: begin
          if (op_known(op_q)) begin
            res_q  <= alu_out;
            cout_q <= alu_cout;
            err_q  <= 1'b0;
          end else begin
            res_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_hs) last_grant <= tag_q;
        end
        default: ;
      endcase
    end
  end

  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign alu_opcode  = op_q;
  assign alu_cin     = cin_q;

  assign resp0_valid = (state == ST_RESP) && !tag_q;
  assign resp1_valid = (state == ST_RESP) &&  tag_q;
  assign resp0_out   = res_q;
  assign resp1_out   = res_q;
  assign resp0_cout  = cout_q;
  assign resp1_cout  = cout_q;
  assign resp0_err   = err_q;
  assign resp1_err   = err_q;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - scoreboard bench for alu_rr_arbiter with a behavioural ALU
module tb_alu_rr_arbiter;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req0_cin;
  logic [3:0] req0_opcode, req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_cin;
  logic [3:0] req1_opcode, req1_a, req1_b;
  logic       resp0_valid, resp0_ready, resp0_cout, resp0_err;
  logic [3:0] resp0_out;
  logic       resp1_valid, resp1_ready, resp1_cout, resp1_err;
  logic [3:0] resp1_out;
  logic [3:0] alu_in1, alu_in2, alu_opcode, alu_out;
  logic       alu_cin, alu_cout, busy;

  int checks = 0;
  int failures = 0;
  logic [6:0] sb[$];

  alu_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_out(resp0_out),
    .resp0_cout(resp0_cout), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_out(resp1_out),
    .resp1_cout(resp1_cout), .resp1_err(resp1_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes return deliberate garbage.
  function automatic logic [4:0] alu_f(input logic [3:0] op, a, b, input logic cin);
    case (op)
      4'b0100: return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      4'b0101: return {1'b0, a} - {1'b0, b} - {4'b0, cin};
      4'b1000: return {1'b0, ~a};
      4'b1001: return {1'b0, a | b};
      4'b1010: return {1'b0, a & b};
      4'b1011: return {1'b0, a ^ b};
      4'b1100: return {a[3], a[2:0], 1'b0};
      4'b1101: return {a[0], 1'b0, a[3:1]};
      4'b1110: return {a[0], a[3], a[3:1]};
      4'b1111: return {1'b0, a};
      default: return {1'b1, a ^ b};
    endcase
  endfunction

  always_comb {alu_cout, alu_out} = alu_f(alu_opcode, alu_in1, alu_in2, alu_cin);

  function automatic logic [6:0] expect_of(input logic tag, input logic [3:0] op, a, b, input logic cin);
    logic [4:0] r;
    r = alu_f(op, a, b, cin);
    if (op inside {4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010,
                   4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111})
      return {tag, r[3:0], r[4], 1'b0};
    return {tag, 4'b0000, 1'b0, 1'b1};
  endfunction

  function automatic logic [6:0] cur_resp();
    if (resp1_valid) return {1'b1, resp1_out, resp1_cout, resp1_err};
    return {1'b0, resp0_out, resp0_cout, resp0_err};
  endfunction

  always @(negedge clk) begin
    if (req0_valid && req0_ready) sb.push_back(expect_of(1'b0, req0_opcode, req0_a, req0_b, req0_cin));
    if (req1_valid && req1_ready) sb.push_back(expect_of(1'b1, req1_opcode, req1_a, req1_b, req1_cin));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic n, input logic [3:0] op, a, b, input logic cin);
    if (n) begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_opcode = '0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_opcode = '0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, busy});
    end
    checks++;
    if ({alu_in1, alu_in2, alu_opcode, alu_cin} !== 13'b0) begin
      failures++;
      $display("FAIL reset_alu_bus got=%h exp=0", {alu_in1, alu_in2, alu_opcode, alu_cin});
    end
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_tie_fairness();
    int n = 0;
    int last_cyc = 0;
    int both_rdy = 0;
    logic [6:0] got, e;
    step();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    drive(1'b0, 4'b1011, 4'b0101, 4'b0011, 1'b0);
    drive(1'b1, 4'b1001, 4'b0100, 4'b0001, 1'b0);
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both_rdy++;
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        got = cur_resp();
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL tie_result got=%b exp=<none queued>", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL tie_result got=%b exp=%b", got, e);
          end
        end
        checks++;
        if (got[6] !== n[0]) begin
          failures++;
          $display("FAIL tie_order resp=%0d got_tag=%b exp_tag=%b", n, got[6], n[0]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            failures++;
            $display("FAIL tie_spacing got=%0d exp=3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
      end
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL tie_count got=%0d exp=4", n);
    end
    checks++;
    if (both_rdy != 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL tie_grants both_ready=%0d leftover=%0d exp=0,0", both_rdy, sb.size());
    end
  endtask

  task automatic test_single();
    logic [6:0] e;
    step();
    drive(1'b0, 4'b1010, 4'b0010, 4'b0011, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp1_valid, busy} !== 3'b001) begin
      failures++;
      $display("FAIL single_issue got=%b exp=001", {resp0_valid, resp1_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({resp0_valid, resp1_valid} !== 2'b10) begin
      failures++;
      $display("FAIL single_resp_valid got=%b exp=10", {resp0_valid, resp1_valid});
    end
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (cur_resp() !== e || {resp0_out, resp0_err} !== 5'b0010_0) begin
      failures++;
      $display("FAIL single_result got=%b exp=%b out_exp=0010", cur_resp(), e);
    end
    step();
    @(negedge clk);
    checks++;
    if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
      failures++;
      $display("FAIL single_done got=%b exp=000", {busy, resp0_valid, resp1_valid});
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    logic [3:0] held;
    logic [6:0] e;
    step();
    resp1_ready = 1'b0; resp0_ready = 1'b1;
    drive(1'b1, 4'b0100, 4'b0111, 4'b0001, 1'b1);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept got=%b exp=1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    drive(1'b0, 4'b1010, 4'b1100, 4'b1010, 1'b0);
    do begin @(negedge clk); w++; end while (!resp1_valid && w < 10);
    held = resp1_out;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({resp1_valid, resp0_valid, busy, req0_ready, resp1_out} !== {4'b1010, held}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%b exp=%b", i,
                 {resp1_valid, resp0_valid, busy, req0_ready, resp1_out}, {4'b1010, held});
      end
    end
    step();
    resp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (cur_resp() !== e || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_result got=%b exp=%b req0_ready=%b", cur_resp(), e, req0_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if ({busy, resp1_valid, req0_ready} !== 3'b001) begin
      failures++;
      $display("FAIL bp_release got=%b exp=001", {busy, resp1_valid, req0_ready});
    end
    step();
    req0_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!resp0_valid && w < 10);
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (!resp0_valid || cur_resp() !== e) begin
      failures++;
      $display("FAIL bp_followup got=%b exp=%b", cur_resp(), e);
    end
    step();
  endtask

  task automatic test_illegal();
    int w = 0;
    logic [6:0] e;
    step();
    resp1_ready = 1'b1;
    drive(1'b1, 4'b0000, 4'b1111, 4'b0101, 1'b1);
    @(negedge clk);
    step();
    req1_valid = 1'b0;
    do begin @(negedge clk); w++; end while (!resp1_valid && w < 10);
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (!resp1_valid || cur_resp() !== e) begin
      failures++;
      $display("FAIL illegal_result got=%b exp=%b", cur_resp(), e);
    end
    checks++;
    if ({resp0_valid, resp1_out, resp1_cout, resp1_err} !== 7'b0_0000_0_1) begin
      failures++;
      $display("FAIL illegal_fields got=%b exp=0000001", {resp0_valid, resp1_out, resp1_cout, resp1_err});
    end
    step();
  endtask

  task automatic test_alu_drive();
    logic [3:0] sampled;
    logic [6:0] e;
    step();
    resp0_ready = 1'b1;
    drive(1'b0, 4'b1100, 4'b0011, 4'b0000, 1'b0);
    @(negedge clk);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, resp0_valid, alu_opcode, alu_in1} !== 10'b10_1100_0011) begin
      failures++;
      $display("FAIL alu_drive_bus got=%b exp=1011000011", {busy, resp0_valid, alu_opcode, alu_in1});
    end
    sampled = alu_out;
    @(negedge clk);
    checks++;
    if (resp0_out !== sampled || resp0_out !== 4'b0110) begin
      failures++;
      $display("FAIL alu_drive_capture got=%b exp=%b (0110)", resp0_out, sampled);
    end
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (cur_resp() !== e) begin
      failures++;
      $display("FAIL alu_drive_result got=%b exp=%b", cur_resp(), e);
    end
    step();
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    int w = 0;
    logic [6:0] e;
    step();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    drive(1'b1, 4'b0101, 4'b1001, 4'b0011, 1'b0);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_accept got=%b exp=1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready,
         alu_in1, alu_in2, alu_opcode, alu_cin} !== 18'b0) begin
      failures++;
      $display("FAIL midop_async got=%b exp=0", {busy, resp0_valid, resp1_valid, req0_ready,
               req1_ready, alu_in1, alu_in2, alu_opcode, alu_cin});
    end
    sb.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midop_no_resp got=%0d active cycles exp=0", seen);
    end
    step();
    drive(1'b0, 4'b1111, 4'b0110, 4'b0000, 1'b0);
    drive(1'b1, 4'b1111, 4'b1001, 4'b0000, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midop_tie got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    do begin @(negedge clk); w++; end while (!resp0_valid && w < 10);
    checks++;
    e = (sb.size() != 0) ? sb.pop_front() : 7'bx;
    if (!resp0_valid || cur_resp() !== e) begin
      failures++;
      $display("FAIL midop_result got=%b exp=%b", cur_resp(), e);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie_fairness();
    test_single();
    test_backpressure();
    test_illegal();
    test_alu_drive();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
